// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, datapath
// select encodings, ALU operation codes and the sequencer state set.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU   = 2'b00,
    RES_MEM   = 2'b01,
    RES_PC4   = 2'b10,
    RES_UPPER = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_e;

  typedef struct packed {
    result_src_e result_src;
    imm_src_e    imm_src;
    alu_ctrl_e   alu_ctrl;
    logic        alu_src;
    logic        reg_write;
    logic        jump;
    logic        branch;
    logic        br_on_zero;  // branch taken when Zero=1 (else when Zero=0)
    logic        jalr;
    logic        load;
    logic        store;
  } dec_t;

  // Register ops use Instr[30] for SUB and SRA; immediate ops only for SRAI.
  function automatic alu_ctrl_e alu_op(input logic [2:0] funct3,
                                       input logic       alt,
                                       input logic       is_reg);
    case (funct3)
      3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: maps the instruction register onto the
// datapath control fields and flags anything outside the supported subset.
module instr_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign alt         = instr[30];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // the block leaves a field unassigned, which would infer a latch.
    dec.result_src = RES_ALU;
    dec.imm_src    = IMM_I;
    dec.alu_ctrl   = ALU_ADD;
    dec.alu_src    = 1'b0;
    dec.reg_write  = 1'b0;
    dec.jump       = 1'b0;
    dec.branch     = 1'b0;
    dec.br_on_zero = 1'b0;
    dec.jalr       = 1'b0;
    dec.load       = 1'b0;
    dec.store      = 1'b0;
    illegal        = 1'b0;

    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = alu_op(funct3, alt, 1'b1);
      end
      OP_I: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = alu_op(funct3, alt, 1'b0);
      end
      OP_LOAD: begin
        dec.alu_src = 1'b1;
        dec.load    = 1'b1;
        illegal     = (funct3 != 3'b010);
      end
      OP_STORE: begin
        dec.alu_src = 1'b1;
        dec.imm_src = IMM_S;
        dec.store   = 1'b1;
        illegal     = (funct3 != 3'b010);
      end
      OP_BRANCH: begin
        dec.branch  = 1'b1;
        dec.imm_src = IMM_B;
        case (funct3)
          3'b000: begin dec.alu_ctrl = ALU_SUB;  dec.br_on_zero = 1'b1; end
          3'b001: begin dec.alu_ctrl = ALU_SUB;  dec.br_on_zero = 1'b0; end
          3'b100: begin dec.alu_ctrl = ALU_SLT;  dec.br_on_zero = 1'b0; end
          3'b101: begin dec.alu_ctrl = ALU_SLT;  dec.br_on_zero = 1'b1; end
          3'b110: begin dec.alu_ctrl = ALU_SLTU; dec.br_on_zero = 1'b0; end
          3'b111: begin dec.alu_ctrl = ALU_SLTU; dec.br_on_zero = 1'b1; end
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        dec.jump       = 1'b1;
        dec.imm_src    = IMM_J;
        dec.result_src = RES_PC4;
        dec.reg_write  = 1'b1;
      end
      OP_JALR: begin
        dec.alu_src    = 1'b1;
        dec.jalr       = 1'b1;
        dec.result_src = RES_PC4;
        dec.reg_write  = 1'b1;
        illegal        = (funct3 != 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        dec.result_src = RES_UPPER;
        dec.reg_write  = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencer: FETCH -> DECODE -> EXEC or MEM -> FETCH over one
// shared variable-latency memory port, with retire counter and bus timeout halt.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        ALUR31,
  input  logic        Carry,
  input  logic        MemReady,
  output logic [1:0]  ResultSrc,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic        Jalr,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        Halted,
  output logic        BusErr,
  output logic [31:0] InstRet
);

  localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q;
  logic [WAIT_W-1:0] wait_q;
  logic [31:0]       inst_ret_q;
  logic              bus_err_q;

  dec_t dec;
  logic illegal;
  logic mem_active;
  logic timeout;
  logic unused_flags;

  assign unused_flags = ALUR31 ^ Carry;

  instr_decode u_decode (
    .instr   (Instr),
    .dec     (dec),
    .illegal (illegal)
  );

  // A ready response in the last tolerated cycle still completes the access.
  assign mem_active = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timeout    = mem_active && !MemReady && (wait_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples the
    // pre-edge values of the others, independent of statement order.
    if (!reset) begin
      state_q    <= ST_FETCH;
      wait_q     <= '0;
      inst_ret_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      wait_q <= (mem_active && !MemReady && !timeout) ? wait_q + 1'b1 : '0;
      case (state_q)
        ST_FETCH: begin
          if (MemReady) begin
            state_q <= ST_DECODE;
          end else if (timeout) begin
            state_q   <= ST_HALT;
            bus_err_q <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (illegal)                    state_q <= ST_HALT;
          else if (dec.load || dec.store) state_q <= ST_MEM;
          else                            state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          state_q    <= ST_FETCH;
          inst_ret_q <= inst_ret_q + 32'd1;
        end
        ST_MEM: begin
          if (MemReady) begin
            state_q    <= ST_FETCH;
            inst_ret_q <= inst_ret_q + 32'd1;
          end else if (timeout) begin
            state_q   <= ST_HALT;
            bus_err_q <= 1'b1;
          end
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_HALT;
      endcase
    end
  end

  // Outputs follow the state and the live MemReady/Zero/reset inputs so that
  // handshakes complete and aborts take effect within the same cycle.
  always_comb begin
    ResultSrc  = RES_ALU;
    PCSrc      = 1'b0;
    ALUSrc     = 1'b0;
    RegWrite   = 1'b0;
    ImmSrc     = IMM_I;
    ALUControl = ALU_ADD;
    Jalr       = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    Halted     = 1'b0;
    BusErr     = 1'b0;
    InstRet    = '0;

    if (reset) begin
      InstRet = inst_ret_q;
      BusErr  = bus_err_q;
      case (state_q)
        ST_FETCH: begin
          MemReq  = 1'b1;
          IRWrite = MemReady;
        end
        ST_EXEC: begin
          ResultSrc  = dec.result_src;
          ALUSrc     = dec.alu_src;
          ImmSrc     = dec.imm_src;
          ALUControl = dec.alu_ctrl;
          Jalr       = dec.jalr;
          RegWrite   = dec.reg_write;
          PCWrite    = 1'b1;
          PCSrc      = dec.jump || (dec.branch && (Zero == dec.br_on_zero));
        end
        ST_MEM: begin
          MemReq     = 1'b1;
          AdrSrc     = 1'b1;
          ALUSrc     = 1'b1;
          ALUControl = ALU_ADD;
          ImmSrc     = dec.store ? IMM_S : IMM_I;
          MemWrite   = dec.store;
          ResultSrc  = dec.load ? RES_MEM : RES_ALU;
          RegWrite   = MemReady && dec.load;
          PCWrite    = MemReady;
        end
        ST_HALT: Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Sequencing controller that runs the RV32I datapath as a multicycle machine over one shared, variable-latency memory port. It fetches into the instruction register, decodes, and issues one execute cycle, or a memory phase for loads and stores. It drives every datapath control input and handles the memory request/ready handshake, the retire counter, and the halt conditions (illegal instruction or bus timeout).

Parameters:
MEM_TIMEOUT, 255, number of consecutive not-ready cycles tolerated on one memory request before a bus error (minimum 1).

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset
Instr  in  32  instruction register contents (valid from DECODE onward)
Zero  in  1  ALU zero flag
ALUR31  in  1  ALU result bit 31 (unused)
Carry  in  1  ALU carry (unused)
MemReady  in  1  memory has completed the current request this cycle
ResultSrc  out  2  00 ALU, 01 ReadData, 10 PC+4, 11 U-type path
PCSrc  out  1  select PC+imm
ALUSrc  out  1  select immediate as SrcB
RegWrite  out  1  register file write enable
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
ALUControl  out  4  ALU operation code
Jalr  out  1  next PC = ALUResult
PCWrite  out  1  PC register load enable
IRWrite  out  1  instruction register load enable
AdrSrc  out  1  memory address: 0 PC, 1 ALUResult
MemReq  out  1  memory request valid
MemWrite  out  1  request is a write (only with MemReq)
Halted  out  1  core stopped
BusErr  out  1  halt caused by memory timeout
InstRet  out  32  retired-instruction count

Behaviour:
- Reset: sampled on the rising edge with reset==0. Sets state to FETCH and clears the wait counter, InstRet and BusErr. While reset is low, every output is forced to 0.
- States: FETCH, DECODE, EXEC, MEM, HALT.
- FETCH:
  - Drives MemReq=1, AdrSrc=0, MemWrite=0.
  - MemReady=1: IRWrite=1 in that cycle, next state DECODE.
  - MemReady=0: stay in FETCH.
- DECODE: one cycle, all enables 0. Legal load/store -> MEM. Other legal instruction -> EXEC. Illegal -> HALT.
- EXEC: one cycle with decoded controls, RegWrite=1 where applicable, PCWrite=1, InstRet+1; next state FETCH.
- MEM:
  - Drives MemReq=1, AdrSrc=1, ALUSrc=1, ALUControl=ADD, ImmSrc=I (loads) or S (stores), MemWrite=1 for stores.
  - All controls held stable until MemReady.
  - On the MemReady cycle: PCWrite=1, InstRet+1, and for loads RegWrite=1 with ResultSrc=01. Next state FETCH.
- Outside the MemReady cycle, RegWrite and PCWrite stay 0.
- Decode table (opcode / action):
  - 0110011 R-type: ALUSrc=0, ResultSrc=00.
  - 0010011 I-ALU: ALUSrc=1, ImmSrc=00, ResultSrc=00. Instr[30] selects SRA only for funct3=101.
  - 0000011 load: lw only (funct3=010).
  - 0100011 store: sw only (funct3=010).
  - 1100011 branch, RegWrite=0:
    - beq/bne: SUB; taken on Zero / !Zero.
    - blt/bge: SLT; bltu/bgeu: SLTU; taken on !Zero (blt, bltu) / Zero (bge, bgeu).
    - funct3 010/011 are illegal.
  - 1101111 jal: PCSrc=1, ImmSrc=11, ResultSrc=10.
  - 1100111 jalr (funct3=000): ALUSrc=1, ImmSrc=00, ADD, Jalr=1, ResultSrc=10.
  - 0110111 lui / 0010111 auipc: ResultSrc=11.
  - Anything else is illegal.
- ALUControl encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
- PCSrc is evaluated only in EXEC, from the Zero value in that cycle.
- Wait counter:
  - Counts each cycle with MemReq=1 and MemReady=0; clears on every state change.
  - A counter already at MEM_TIMEOUT-1 with MemReady=0 moves the FSM to HALT and sets BusErr=1.
  - MemReady=1 in the same cycle always wins over timeout.
- HALT: Halted=1; every enable and MemReq is 0. Only reset leaves HALT.
- MemReady while MemReq=0 is ignored.
- InstRet wraps from 0xFFFFFFFF to 0.
- Reset low mid-request aborts the access immediately: MemReq drops in the same cycle.

Decomposition:
- Package riscv_ctrl_pkg holds the opcode constants, ALUControl/ImmSrc/ResultSrc encodings, and the state enumeration.
- Sub-module instr_decode: combinational Instr -> control fields plus an illegal flag. The FSM, wait counter and InstRet stay in multicycle_ctrl.

Test Plan:
1. reset=0 for 2 cycles, then 1; MemReady=1; Instr=0x002081B3 (add) -> IRWrite in cycle 1; EXEC in cycle 3 with ALUControl=0000, ALUSrc=0, RegWrite=1, PCWrite=1; InstRet=1 afterwards.
2. lw 0x00802283, MemReady low for 3 MEM cycles -> MemReq=1, AdrSrc=1, MemWrite=0 for 4 cycles; RegWrite=PCWrite=1 with ResultSrc=01 only in cycle 4.
3. beq 0x00208463 with Zero=1 -> PCSrc=1, ImmSrc=10, RegWrite=0; same with Zero=0 -> PCSrc=0; blt 0x0020C463 with Zero=0 -> ALUControl=0101, PCSrc=1.
4. Instr=0x00000000 -> DECODE -> HALT; Halted=1, BusErr=0, no RegWrite/PCWrite; still halted 10 cycles later.
5. MEM_TIMEOUT=4, MemReady held 0 in FETCH -> HALT after 4 unready cycles, BusErr=1. Same run with MemReady=1 on cycle 4 -> DECODE, no error.
6. reset=0 during an sw MEM wait -> all outputs 0 that cycle; after release FETCH with MemReq=1, InstRet=0.
